// File: rtl/capture_sequencer.sv
// Frame capture sequencer: arm, wait for a settled ADC, holdoff, then edge trigger,
// stream DEPTH samples into one ping-pong half and swap halves when the host is idle.
module capture_sequencer #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned HOLD_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  single,
    input  logic                  trig_edge,
    input  logic [HOLD_W-1:0]     holdoff,
    input  logic                  stable,
    input  logic                  trig_in,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic                  host_busy,
    input  logic                  clr_overrun,
    output logic                  buf_we,
    output logic                  buf_sel,
    output logic [ADDR_W-1:0]     buf_addr,
    output logic [DATA_WIDTH-1:0] buf_wdata,
    output logic                  host_buf,
    output logic                  frame_ready,
    output logic                  frame_done,
    output logic                  overrun,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT_STABLE = 3'd1,
        S_HOLDOFF     = 3'd2,
        S_WAIT_TRIG   = 3'd3,
        S_CAPTURE     = 3'd4,
        S_SWAP        = 3'd5
    } state_t;

    state_t                r_state;
    logic [ADDR_W-1:0]     r_cnt;
    logic [HOLD_W-1:0]     r_hold;
    logic                  r_trig_q;
    logic                  r_busy_q;
    logic                  r_buf_we;
    logic                  r_buf_sel;
    logic [ADDR_W-1:0]     r_buf_addr;
    logic [DATA_WIDTH-1:0] r_buf_wdata;
    logic                  r_frame_ready;
    logic                  r_frame_done;
    logic                  r_overrun;

    logic                  w_edge;
    logic                  w_busy_rise;

    assign w_edge      = trig_edge ? (r_trig_q & ~trig_in) : (~r_trig_q & trig_in);
    assign w_busy_rise = host_busy & ~r_busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_hold        <= '0;
            r_trig_q      <= 1'b0;
            r_busy_q      <= 1'b0;
            r_buf_we      <= 1'b0;
            r_buf_sel     <= 1'b0;
            r_buf_addr    <= '0;
            r_buf_wdata   <= '0;
            r_frame_ready <= 1'b0;
            r_frame_done  <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_trig_q     <= trig_in;
            r_busy_q     <= host_busy;
            r_buf_we     <= 1'b0;
            r_frame_done <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
            end else begin
                // Clears come first so a coincident set further down takes precedence.
                if (w_busy_rise) r_frame_ready <= 1'b0;
                if (clr_overrun) r_overrun <= 1'b0;
                case (r_state)
                    S_IDLE: begin
                        if (arm) r_state <= S_WAIT_STABLE;
                    end
                    S_WAIT_STABLE: begin
                        if (stable) begin
                            r_hold  <= holdoff;
                            r_state <= (holdoff == '0) ? S_WAIT_TRIG : S_HOLDOFF;
                        end
                    end
                    S_HOLDOFF: begin
                        r_hold <= r_hold - 1'b1;
                        if (!stable)
                            r_state <= S_WAIT_STABLE;
                        else if (r_hold == HOLD_W'(1))
                            r_state <= S_WAIT_TRIG;
                    end
                    S_WAIT_TRIG: begin
                        if (!stable) begin
                            r_state <= S_WAIT_STABLE;
                        end else if (w_edge) begin
                            r_cnt   <= '0;
                            r_state <= S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        if (sample_valid) begin
                            r_buf_we    <= 1'b1;
                            r_buf_addr  <= r_cnt;
                            r_buf_wdata <= sample_data;
                            r_cnt       <= r_cnt + 1'b1;
                            if (r_cnt == ADDR_W'(DEPTH - 1)) r_state <= S_SWAP;
                        end
                    end
                    S_SWAP: begin
                        if (host_busy) begin
                            if (sample_valid) r_overrun <= 1'b1;
                        end else begin
                            r_buf_sel     <= ~r_buf_sel;
                            r_frame_ready <= 1'b1;
                            r_frame_done  <= 1'b1;
                            if (single) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_hold  <= holdoff;
                                r_state <= (holdoff == '0) ? S_WAIT_TRIG : S_HOLDOFF;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign buf_we      = r_buf_we;
    assign buf_sel     = r_buf_sel;
    assign buf_addr    = r_buf_addr;
    assign buf_wdata   = r_buf_wdata;
    assign host_buf    = ~r_buf_sel;
    assign frame_ready = r_frame_ready;
    assign frame_done  = r_frame_done;
    assign overrun     = r_overrun;
    assign state       = r_state;

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Controls ADC frame capture into the ping-pong sample buffer.
- Arms on command, waits for the ADC to report stable, applies a programmable holdoff, then waits for a selected edge on the comparator square wave.
- On trigger, streams exactly DEPTH samples into the active half, then swaps halves only when the host (FSMC side) is not reading.
- Sits between the ADC/comparator synchronisers and the buffer RAM write port, with a status/handshake path to the FSMC register block.

Parameters:
DATA_WIDTH, 12, ADC sample width
DEPTH, 1024, samples per frame (power of two)
ADDR_W, 10, log2(DEPTH)
HOLD_W, 16, holdoff counter width

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
arm  in  1  one-cycle start pulse; honoured only in IDLE
abort  in  1  one-cycle pulse; returns to IDLE from any state
single  in  1  1 = one frame then IDLE; 0 = continuous re-arm
trig_edge  in  1  0 = rising edge of trig_in, 1 = falling edge
holdoff  in  HOLD_W  clk cycles to wait before trigger search
stable  in  1  ADC settled (already synchronised)
trig_in  in  1  comparator square wave (already synchronised)
sample_valid  in  1  one-cycle strobe per new ADC sample
sample_data  in  DATA_WIDTH  ADC sample, valid with sample_valid
host_busy  in  1  host read-state register; 1 = host reading host_buf
clr_overrun  in  1  clears overrun
buf_we  out  1  buffer write enable
buf_sel  out  1  half being written
buf_addr  out  ADDR_W  write address
buf_wdata  out  DATA_WIDTH  write data
host_buf  out  1  half the host may read (always equals ~buf_sel)
frame_ready  out  1  new frame available in host_buf
frame_done  out  1  one-cycle pulse on every swap
overrun  out  1  sticky; a sample was dropped waiting for the host
state  out  3  IDLE=0, WAIT_STABLE=1, HOLDOFF=2, WAIT_TRIG=3, CAPTURE=4, SWAP=5

Behaviour:
- Reset values:
  - state = IDLE.
  - buf_we, frame_ready, frame_done and overrun = 0.
  - buf_sel = 0 and host_buf = 1.
  - buf_addr and buf_wdata = 0.
  - Sample counter and holdoff counter = 0.
  - The trig_in history register = 0.
- Reset mid-operation: takes effect on the same edge. The partial frame is discarded.
- Priority: rst > abort > everything else.
  - abort in any state: go to IDLE next cycle, buf_we = 0, buf_sel unchanged, frame_ready unchanged.
- IDLE: arm=1 goes to WAIT_STABLE. arm outside IDLE is ignored.
- WAIT_STABLE: stable=1 loads the holdoff counter with holdoff and goes to HOLDOFF. If holdoff == 0, go directly to WAIT_TRIG.
- HOLDOFF:
  - The counter decrements each cycle.
  - Go to WAIT_TRIG on the cycle the counter reads 1.
  - stable=0 returns to WAIT_STABLE.
- WAIT_TRIG:
  - Edge detect compares trig_in against a 1-cycle registered copy; the history register updates in every state.
  - On the selected edge, go to CAPTURE and clear the sample counter.
  - stable=0 returns to WAIT_STABLE.
  - An edge present on the same cycle as the entry into WAIT_TRIG counts.
- CAPTURE:
  - stable and trig_in are ignored.
  - Each sample_valid produces, on the next cycle: buf_we=1 for exactly one cycle, buf_addr = counter, buf_wdata = sample_data. The counter then increments.
  - Latency from sample_valid to buf_we is 1 clk.
  - The write at address DEPTH-1 also moves the FSM to SWAP. The counter wraps to 0.
- SWAP:
  - If host_busy=0 on the cycle SWAP is entered:
    - buf_sel flips and host_buf follows (host_buf = ~buf_sel).
    - frame_ready=1.
    - frame_done pulses for 1 cycle.
    - Next state is IDLE if single=1; otherwise the holdoff is reloaded and the FSM goes to HOLDOFF (or to WAIT_TRIG if holdoff == 0).
  - If host_busy=1: remain in SWAP with no flip.
    - Any sample_valid here is dropped and sets overrun=1.
    - Swap on the first cycle host_busy=0.
- frame_ready:
  - Cleared on a rising edge of host_busy (host has started reading).
  - If a swap and that clear coincide, set wins.
- overrun:
  - Cleared by clr_overrun.
  - If set and clear coincide, set wins.
- Host-side buffer ownership: host_buf never changes while host_busy=1.
- Address arithmetic is modulo DEPTH. No write ever occurs outside CAPTURE.

Test Plan:
- Single frame:
  - Stimulus: single=1, holdoff=5, stable=1, arm pulse, rising edge on trig_in, 1024 samples of value i.
  - Required: exactly 1024 buf_we pulses, with addr i and data i on buf_sel=0.
  - Required after: frame_done pulses once, buf_sel=1, host_buf=0, frame_ready=1, state returns to IDLE.
- Holdoff and edge select:
  - Stimulus: holdoff=20, trig_edge=1, rising edges only during the first 30 cycles, falling edge at cycle 40.
  - Required: no capture before cycle 40; CAPTURE is entered at cycle 41.
- Host blocking:
  - Stimulus: continuous mode; host_busy=1 when frame 2 completes; 3 samples arrive during the wait; host_busy drops 50 cycles later.
  - Required: state holds at 5, overrun=1, no buf_we.
  - Required when host_busy drops: swap on the next edge, host_buf toggles, frame_done pulses.
- Stable loss:
  - Stimulus: stable drops during HOLDOFF and during WAIT_TRIG.
  - Required: the FSM returns to WAIT_STABLE.
  - Stimulus: stable drops during CAPTURE.
  - Required: the frame completes all 1024 writes.
- Abort and reset mid-capture:
  - Stimulus: abort at sample 500.
  - Required: IDLE next cycle, buf_sel unchanged, no frame_done.
  - Stimulus: rst at sample 300.
  - Required: all outputs at their reset values on the following cycle.
- Flag collisions:
  - Stimulus: clr_overrun coincides with a new drop.
  - Required: overrun stays 1.
  - Stimulus: a host_busy rising edge coincides with a swap.
  - Required: frame_ready stays 1.
